// File: rtl/makestuff_chunk_consumer_pkg.sv
// Shared types and sizing helpers for the C2F chunk consumer and its checksum datapath.
package makestuff_chunk_consumer_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    GOBBLE   = 2'd1,
    THROTTLE = 2'd2
  } mode_e;

  typedef enum logic {
    ADD = 1'b0,
    XOR = 1'b1
  } ckop_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_LAST = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  function automatic int chunk_words(input int offset_nbits);
    return 32'sd1 << offset_nbits;
  endfunction

  // A one-word chunk still needs a one-bit offset port.
  function automatic int offset_width(input int offset_nbits);
    return (offset_nbits == 32'sd0) ? 32'sd1 : offset_nbits;
  endfunction

endpackage

// File: rtl/makestuff_cksum_accum.sv
// Running checksum register: folds one word per enabled cycle by add or XOR,
// with a clear that zeroes the prior sum before any fold in the same cycle.
module makestuff_cksum_accum
  import makestuff_chunk_consumer_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  op_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [DATA_WIDTH-1:0] sum_o
);

  logic [DATA_WIDTH-1:0] sum_q;
  logic [DATA_WIDTH-1:0] sum_d;
  logic [DATA_WIDTH-1:0] base_s;

  // Next checksum value from clear, enable and the selected operator.
  always_comb begin
    base_s = clr_i ? {DATA_WIDTH{1'b0}} : sum_q;
    sum_d  = base_s;
    if (en_i) begin
      if (op_i == XOR) begin
        sum_d = base_s ^ word_i;
      end else begin
        sum_d = base_s + word_i;
      end
    end else begin
      sum_d = base_s;
    end
  end

  // Checksum register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= {DATA_WIDTH{1'b0}};
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/makestuff_chunk_consumer.sv
// Drains chunks from the C2F chunk RAM word by word, folds them into a checksum,
// and acknowledges each chunk immediately (GOBBLE) or after a programmable delay (THROTTLE).
module makestuff_chunk_consumer
  import makestuff_chunk_consumer_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int OFFSET_NBITS = 4,
  parameter int PTR_NBITS    = 2,
  parameter int COUNT_NBITS  = 32,
  localparam int OFF_W       = offset_width(OFFSET_NBITS)
) (
  input  logic                   sysClk_in,
  input  logic                   sysRstN_in,
  input  logic [PTR_NBITS-1:0]   wrPtr_in,
  input  logic [PTR_NBITS-1:0]   rdPtr_in,
  output logic                   dtAck_out,
  output logic [OFF_W-1:0]       rdOffset_out,
  input  logic [DATA_WIDTH-1:0]  rdData_in,
  input  logic [1:0]             mode_in,
  input  logic                   ckOp_in,
  input  logic [COUNT_NBITS-1:0] countInit_in,
  input  logic                   csReset_in,
  output logic [DATA_WIDTH-1:0]  csData_out,
  output logic                   csValid_out,
  output logic [COUNT_NBITS-1:0] chunkCount_out
);

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(chunk_words(OFFSET_NBITS) - 32'sd1);

  state_e                 state_q;
  mode_e                  mode_q;
  logic                   ckop_q;
  logic [OFF_W-1:0]       offset_q;
  logic [COUNT_NBITS-1:0] count_q;
  logic [COUNT_NBITS-1:0] chunk_count_q;

  mode_e mode_in_s;
  logic  start_s;
  logic  ack_s;
  logic  acc_en_s;

  assign mode_in_s = mode_e'(mode_in);

  // Chunk start and acknowledge decode; mode 3 is treated like DISABLED.
  always_comb begin
    start_s = 1'b0;
    ack_s   = 1'b0;
    if ((state_q == S_IDLE) && (wrPtr_in != rdPtr_in) &&
        ((mode_in_s == GOBBLE) || (mode_in_s == THROTTLE))) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
    case (state_q)
      S_LAST:  ack_s = (mode_q == GOBBLE) || (countInit_in == {COUNT_NBITS{1'b0}});
      S_WAIT:  ack_s = (count_q == {COUNT_NBITS{1'b0}});
      default: ack_s = 1'b0;
    endcase
  end

  // Chunk sequencing FSM with latched per-chunk mode and operator.
  always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
    if (!sysRstN_in) begin
      state_q       <= S_IDLE;
      mode_q        <= DISABLED;
      ckop_q        <= 1'b0;
      offset_q      <= {OFF_W{1'b0}};
      count_q       <= {COUNT_NBITS{1'b0}};
      chunk_count_q <= {COUNT_NBITS{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            mode_q <= mode_in_s;
            ckop_q <= ckOp_in;
            if (LAST_OFF == {OFF_W{1'b0}}) begin
              state_q <= S_LAST;
            end else begin
              state_q  <= S_READ;
              offset_q <= OFF_W'(1);
            end
          end
        end
        S_READ: begin
          if (offset_q == LAST_OFF) begin
            state_q <= S_LAST;
          end else begin
            offset_q <= offset_q + OFF_W'(1);
          end
        end
        S_LAST: begin
          if (ack_s) begin
            state_q       <= S_IDLE;
            chunk_count_q <= chunk_count_q + COUNT_NBITS'(1);
          end else begin
            count_q <= countInit_in - COUNT_NBITS'(1);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack_s) begin
            state_q       <= S_IDLE;
            chunk_count_q <= chunk_count_q + COUNT_NBITS'(1);
          end else begin
            count_q <= count_q - COUNT_NBITS'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read data lags the offset by one cycle, so READ and LAST each fold the previous word.
  assign acc_en_s = (state_q == S_READ) || (state_q == S_LAST);

  makestuff_cksum_accum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_accum (
    .clk_i (sysClk_in),
    .rst_ni(sysRstN_in),
    .en_i  (acc_en_s),
    .clr_i (csReset_in),
    .op_i  (ckop_q),
    .word_i(rdData_in),
    .sum_o (csData_out)
  );

  assign dtAck_out      = ack_s;
  assign rdOffset_out   = (state_q == S_IDLE) ? {OFF_W{1'b0}} : offset_q;
  assign csValid_out    = (wrPtr_in == rdPtr_in) && (state_q == S_IDLE);
  assign chunkCount_out = chunk_count_q;

endmodule

// File: tb/tb_makestuff_chunk_consumer.sv
// Bench for makestuff_chunk_consumer: a 16-word instance and a 1-word instance,
// each fed by a modelled chunk RAM and an upstream read pointer that follows dtAck_out.
module tb_makestuff_chunk_consumer;
  import makestuff_chunk_consumer_pkg::*;

  localparam int DW = 64;
  localparam int N  = 16;
  localparam int PW = 2;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [PW-1:0] wr_a, wr_b;
  logic [PW-1:0] rd_a = '0;
  logic [PW-1:0] rd_b = '0;
  logic          ack_a, ack_b;
  logic [3:0]    off_a;
  logic [0:0]    off_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [1:0]    mode_a, mode_b;
  logic          op_a, op_b;
  logic [CW-1:0] ci_a, ci_b;
  logic          csr_a, csr_b;
  logic [DW-1:0] cs_a, cs_b;
  logic          val_a, val_b;
  logic [CW-1:0] cnt_a, cnt_b;

  makestuff_chunk_consumer #(.DATA_WIDTH(DW), .OFFSET_NBITS(4), .PTR_NBITS(PW), .COUNT_NBITS(CW)) dut (
    .sysClk_in(clk), .sysRstN_in(rst_n), .wrPtr_in(wr_a), .rdPtr_in(rd_a), .dtAck_out(ack_a),
    .rdOffset_out(off_a), .rdData_in(rdata_a), .mode_in(mode_a), .ckOp_in(op_a),
    .countInit_in(ci_a), .csReset_in(csr_a), .csData_out(cs_a), .csValid_out(val_a),
    .chunkCount_out(cnt_a));

  makestuff_chunk_consumer #(.DATA_WIDTH(DW), .OFFSET_NBITS(0), .PTR_NBITS(PW), .COUNT_NBITS(CW)) dut1 (
    .sysClk_in(clk), .sysRstN_in(rst_n), .wrPtr_in(wr_b), .rdPtr_in(rd_b), .dtAck_out(ack_b),
    .rdOffset_out(off_b), .rdData_in(rdata_b), .mode_in(mode_b), .ckOp_in(op_b),
    .countInit_in(ci_b), .csReset_in(csr_b), .csData_out(cs_b), .csValid_out(val_b),
    .chunkCount_out(cnt_b));

  logic [DW-1:0] ram_a [4][16];
  logic [DW-1:0] ram_b [4];

  int cyc = 0;
  int acks_a[$];
  int acks_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Environment: RAM with one-cycle read latency, upstream pointers, cycle counter, ack log.
  always @(posedge clk) begin
    rdata_a <= ram_a[rd_a][off_a];
    rdata_b <= ram_b[rd_b];
    if (ack_a) rd_a <= rd_a + 2'd1;
    if (ack_b) rd_b <= rd_b + 2'd1;
    if (ack_a) acks_a.push_back(cyc);
    if (ack_b) acks_b.push_back(cyc);
    cyc <= cyc + 1;
  end

  logic [DW-1:0] exp_cs_a, exp_cs_b;
  int            exp_cnt_a, exp_cnt_b;

  function automatic logic [DW-1:0] fold(input logic [DW-1:0] c, input logic o, input logic [DW-1:0] w);
    return o ? (c ^ w) : (c + w);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_ack_a(output int c, input int budget);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (acks_a.size() > 0) begin
        c = acks_a.pop_front();
        break;
      end
    end
  endtask

  task automatic wait_ack_b(output int c, input int budget);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (acks_b.size() > 0) begin
        c = acks_b.pop_front();
        break;
      end
    end
  endtask

  // Queue nch chunks on the 16-word instance and check latency, checksum, count, valid.
  task automatic run_a(input logic [1:0] m, input logic o, input int ci, input int nch,
                       input bit fixed, input string tag);
    int s, a, prev, lat;
    logic [PW-1:0] idx;
    logic [DW-1:0] w;
    @(negedge clk);
    for (int k = 0; k < nch; k++) begin
      idx = wr_a + PW'(k);
      for (int j = 0; j < N; j++) begin
        w = fixed ? DW'(j + 1) : {$urandom, $urandom};
        ram_a[idx][j] = w;
        exp_cs_a = fold(exp_cs_a, o, w);
      end
    end
    mode_a = m; op_a = o; ci_a = CW'(ci);
    wr_a = wr_a + PW'(nch);
    s = cyc;
    lat = N + ((m == 2'd2) ? ci : 0);
    if (nch == 1) begin
      @(negedge clk);
      mode_a = 2'd3;
      op_a = ~o;
    end
    prev = s - 1;
    for (int k = 0; k < nch; k++) begin
      wait_ack_a(a, lat + 20);
      check({tag, "_ack_cycle"}, 64'(a), 64'(prev + 1 + lat));
      if (a < 0) break;
      prev = a;
    end
    exp_cnt_a += nch;
    check({tag, "_cs"}, cs_a, exp_cs_a);
    check({tag, "_count"}, 64'(cnt_a), 64'(exp_cnt_a));
    check({tag, "_valid"}, 64'(val_a), 64'd1);
  endtask

  int s, a, a2;
  logic [DW-1:0] w;

  initial begin
    rst_n = 1'b0;
    wr_a = '0; wr_b = '0;
    mode_a = 2'd0; mode_b = 2'd0; op_a = 1'b0; op_b = 1'b0;
    ci_a = '0; ci_b = '0; csr_a = 1'b0; csr_b = 1'b0;
    exp_cs_a = '0; exp_cs_b = '0; exp_cnt_a = 0; exp_cnt_b = 0;
    #1;
    check("rst_ack", 64'(ack_a), 64'd0);
    check("rst_off", 64'(off_a), 64'd0);
    check("rst_cs", cs_a, 64'd0);
    check("rst_cnt", 64'(cnt_a), 64'd0);
    check("rst_valid", 64'(val_a), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Words 1..16 summed in GOBBLE mode; countInit must be ignored.
    run_a(2'd1, 1'b0, 7, 1, 1'b1, "gobble_add");
    check("gobble_add_136", cs_a, 64'd136);

    run_a(2'd2, 1'b0, 5, 2, 1'b0, "throttle5_x2");

    // Clear coinciding with the fold of word 1 (value 7) after word 0 (value 100).
    @(negedge clk);
    csr_a = 1'b1;
    @(negedge clk);
    csr_a = 1'b0;
    ram_a[wr_a][0] = 64'd100;
    ram_a[wr_a][1] = 64'd7;
    exp_cs_a = 64'd7;
    for (int j = 2; j < N; j++) begin
      w = {$urandom, $urandom};
      ram_a[wr_a][j] = w;
      exp_cs_a = exp_cs_a + w;
    end
    mode_a = 2'd1; op_a = 1'b0;
    wr_a = wr_a + 2'd1;
    s = cyc;
    @(negedge clk);
    @(negedge clk);
    check("csr_before", cs_a, 64'd100);
    csr_a = 1'b1;
    @(negedge clk);
    csr_a = 1'b0;
    check("csr_word7", cs_a, 64'd7);
    wait_ack_a(a, N + 20);
    check("csr_ack_cycle", 64'(a), 64'(s + N));
    exp_cnt_a++;
    check("csr_final", cs_a, exp_cs_a);

    // Randomized chunks with random mode, operator, delay and queue depth.
    for (int t = 0; t < 6; t++) begin
      run_a(2'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(1, 2), 1'b0, "rand");
    end

    // One-word chunks, XOR: 0xA5 ^ 0x0F.
    @(negedge clk);
    csr_b = 1'b1;
    @(negedge clk);
    csr_b = 1'b0;
    ram_b[wr_b] = 64'hA5;
    ram_b[wr_b + 2'd1] = 64'h0F;
    mode_b = 2'd1; op_b = 1'b1;
    wr_b = wr_b + 2'd2;
    s = cyc;
    wait_ack_b(a, 20);
    check("n1_xor_ack1", 64'(a), 64'(s + 1));
    wait_ack_b(a2, 20);
    check("n1_xor_ack2", 64'(a2), 64'(s + 3));
    check("n1_xor_cs", cs_b, 64'hAA);
    exp_cnt_b += 2;
    check("n1_xor_count", 64'(cnt_b), 64'(exp_cnt_b));

    // One-word chunks, ADD wrapping past 2**64.
    @(negedge clk);
    csr_b = 1'b1;
    @(negedge clk);
    csr_b = 1'b0;
    ram_b[wr_b] = 64'hFFFF_FFFF_FFFF_FFFF;
    ram_b[wr_b + 2'd1] = 64'h2;
    op_b = 1'b0;
    wr_b = wr_b + 2'd2;
    wait_ack_b(a, 20);
    wait_ack_b(a2, 20);
    check("n1_add_ack_gap", 64'(a2 - a), 64'd2);
    check("n1_add_cs", cs_b, 64'h1);
    check("n1_valid", 64'(val_b), 64'd1);

    // Reset while waiting out a long throttle delay.
    @(negedge clk);
    for (int j = 0; j < N; j++) ram_a[wr_a][j] = {$urandom, $urandom};
    mode_a = 2'd2; op_a = 1'b0; ci_a = 32'd40;
    wr_a = wr_a + 2'd1;
    repeat (N + 5) @(negedge clk);
    rst_n = 1'b0;
    mode_a = 2'd0;
    #1;
    check("wrst_ack", 64'(ack_a), 64'd0);
    check("wrst_off", 64'(off_a), 64'd0);
    check("wrst_cs", cs_a, 64'd0);
    check("wrst_cnt", 64'(cnt_a), 64'd0);
    check("wrst_cs_b", cs_b, 64'd0);
    check("wrst_off_b", 64'(off_b), 64'd0);
    check("wrst_valid", 64'(val_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("dis_no_ack", 64'(acks_a.size()), 64'd0);
    check("dis_valid", 64'(val_a), 64'd0);
    check("dis_off", 64'(off_a), 64'd0);
    check("dis_cnt", 64'(cnt_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/makestuff_chunk_consumer.md
Name: makestuff_chunk_consumer

Overview:
Parametrised successor to the C2F example consumer. Drains chunks from the C2F chunk RAM whenever the producer's write pointer is ahead of the read pointer. Reads each chunk word-by-word, folds every word into a running checksum (add or XOR), and acknowledges the chunk after a selectable throttle delay. Sits between the TLP transceiver's C2F chunk buffer and the host-visible status registers; used for bandwidth and back-pressure testing of the C2F path.

Parameters:
DATA_WIDTH, 64, width of one chunk word and of the checksum
OFFSET_NBITS, 4, chunk holds N = 2**OFFSET_NBITS words; 0 is legal (N=1)
PTR_NBITS, 2, width of the chunk ring pointers
COUNT_NBITS, 32, width of the throttle counter and the chunk counter

Ports:
sysClk_in  in  1  system clock; all logic is on its rising edge
sysRstN_in  in  1  reset; asynchronous and active-low
wrPtr_in  in  PTR_NBITS  producer write pointer
rdPtr_in  in  PTR_NBITS  consumer read pointer, owned upstream; advances the cycle after dtAck_out
dtAck_out  out  1  one-cycle pulse: current chunk consumed
rdOffset_out  out  OFFSET_NBITS  word address into the current chunk
rdData_in  in  DATA_WIDTH  RAM read data; one-cycle latency from rdOffset_out
mode_in  in  2  0=DISABLED, 1=GOBBLE, 2=THROTTLE, 3=reserved (treated as DISABLED)
ckOp_in  in  1  0=add modulo 2**DATA_WIDTH, 1=XOR
countInit_in  in  COUNT_NBITS  THROTTLE delay in cycles
csReset_in  in  1  synchronous checksum clear
csData_out  out  DATA_WIDTH  running checksum
csValid_out  out  1  high when wrPtr_in==rdPtr_in and state is S_IDLE
chunkCount_out  out  COUNT_NBITS  chunks acknowledged since reset; wraps

Behaviour:
- Reset (sysRstN_in low, asynchronous): state=S_IDLE, checksum=0, chunkCount=0, throttle count=0, dtAck_out=0, rdOffset_out=0. Reset asserted mid-chunk abandons the chunk; no ack is issued.
- S_IDLE:
  - rdOffset_out=0.
  - Starts a chunk when the mode is not DISABLED and wrPtr_in!=rdPtr_in.
  - On start, latches mode_in and ckOp_in for the whole chunk; later changes to either have no effect until the next chunk.
  - Next state: N=1 -> S_LAST, otherwise S_READ with the offset register set to 1.
- S_READ:
  - Drives rdOffset_out=offset.
  - Accumulates rdData_in, which is word offset-1.
  - offset increments; when offset == N-1 it moves to S_LAST.
- S_LAST:
  - Accumulates word N-1.
  - GOBBLE, or THROTTLE with countInit_in==0: dtAck_out=1, chunkCount increments, next state S_IDLE.
  - THROTTLE with countInit_in>0: loads count=countInit_in-1, next state S_WAIT.
- S_WAIT: count decrements; when count==0, dtAck_out=1, chunkCount increments, next state S_IDLE.
- Latency: dtAck_out is asserted in cycle N after the start cycle (GOBBLE), or N+countInit_in (THROTTLE).
- Back-to-back chunks: S_IDLE re-evaluates the pointers in the cycle after dtAck_out, when rdPtr_in has already advanced. There is therefore exactly one idle cycle between chunks.
- Accumulate: ck_next = (csReset_in ? 0 : ck) OP word. A clear coinciding with an accumulate leaves the checksum equal to that word. Outside accumulate cycles, csReset_in simply clears.
- Arithmetic: the add truncates to DATA_WIDTH bits. chunkCount and count wrap modulo 2**COUNT_NBITS.
- Pointer wrap-around is handled by equality compare only; the block never inspects ring occupancy.
- csData_out and chunkCount_out are registered. dtAck_out and rdOffset_out are combinational from state.

Decomposition:
- Package makestuff_chunk_consumer_pkg:
  - Mode enum: DISABLED, GOBBLE, THROTTLE.
  - CkOp enum: ADD, XOR.
  - State enum: S_IDLE, S_READ, S_LAST, S_WAIT.
  - Function returning N from OFFSET_NBITS.
- Sub-module makestuff_cksum_accum (DATA_WIDTH; inputs en, clr, op, word; output sum) isolates the checksum datapath so it can be reused by the F2C-side generator.

Test Plan:
- GOBBLE, ADD, N=16, words 1..16, one chunk -> csData_out=136; dtAck_out pulses exactly at cycle 16 after start; chunkCount_out=1; csValid_out=1 afterwards.
- THROTTLE, countInit_in=5, two chunks queued -> acks at start+21 and next start+21; exactly one idle cycle between chunks; chunkCount_out=2.
- XOR, N=1 (OFFSET_NBITS=0), word 0xA5 then 0x0F -> csData_out=0xAA; each ack one cycle after its start.
- ADD overflow: words 0xFFFF_FFFF_FFFF_FFFF and 0x2 -> csData_out=0x1.
- csReset_in pulsed during the S_READ accumulate of word value 7, with previous sum 100 -> checksum=7, then continues accumulating.
- sysRstN_in low during S_WAIT -> no dtAck_out; all outputs at reset values; mode_in=DISABLED afterwards with wrPtr_in!=rdPtr_in -> stays in S_IDLE, csValid_out=0.
